// File: rtl/motion_pkg.sv
// Shared motion types: move command record and dispatcher FSM states.
// Used by move_queue_dispatcher and move_fifo.
package motion_pkg;

  localparam int MQ_DEPTH = 16;

  typedef struct packed {
    logic        [31:0] speed;
    logic signed [31:0] num_x;
    logic signed [31:0] num_y;
    logic signed [31:0] num_z;
    logic signed [31:0] num_e0;
    logic signed [31:0] num_e1;
  } move_cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    ARM   = 3'd3,
    RUN   = 3'd4,
    FAULT = 3'd5
  } mqd_state_t;

  function automatic logic is_zero_move(input move_cmd_t m);
    return (m.num_x == 0) && (m.num_y == 0) && (m.num_z == 0) &&
           (m.num_e0 == 0) && (m.num_e1 == 0);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// DEPTH-entry FIFO of move commands with synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module move_fifo
  import motion_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  move_cmd_t     wdata,
  output move_cmd_t     rdata,
  output logic [AW:0]   level,
  output logic          full
);

  move_cmd_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  // Flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/move_queue_dispatcher.sv
// Queues move commands and hands them one at a time to the motion core.
// Define MOVE_QUEUE_SKIP_ZERO_EN to drop moves whose axis counts are all zero.
module move_queue_dispatcher
  import motion_pkg::*;
#(
  parameter int DEPTH = MQ_DEPTH,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic        [31:0] cmd_speed,
  input  logic signed [31:0] cmd_num_x,
  input  logic signed [31:0] cmd_num_y,
  input  logic signed [31:0] cmd_num_z,
  input  logic signed [31:0] cmd_num_e0,
  input  logic signed [31:0] cmd_num_e1,
  output logic        [31:0] speed,
  output logic signed [31:0] num_x_m,
  output logic signed [31:0] num_y_m,
  output logic signed [31:0] num_z_m,
  output logic signed [31:0] num_e0_m,
  output logic signed [31:0] num_e1_m,
  output logic               start_driving_main,
  input  logic               finish,
  input  logic               error,
  input  logic               fault_clear,
  output logic               busy,
  output logic               fault,
  output logic [AW:0]        level
);

  mqd_state_t  state_q, state_d;
  move_cmd_t   out_q, out_d;
  logic        err_q, err_d;
  move_cmd_t   wdata, head;
  logic        full, push, pop, flush, fault_hit;

  assign wdata = '{speed: cmd_speed, num_x: cmd_num_x, num_y: cmd_num_y,
                   num_z: cmd_num_z, num_e0: cmd_num_e0, num_e1: cmd_num_e1};

  assign cmd_ready = !full && (state_q != FAULT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == LOAD);
  assign fault_hit = (state_q == RUN) && (error || err_q);
  assign flush     = fault_hit || (state_q == FAULT);

  move_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .level (level),
    .full  (full)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  if (level != '0) state_d = LOAD;
      LOAD: begin
        err_d = 1'b0;
`ifdef MOVE_QUEUE_SKIP_ZERO_EN
        if (is_zero_move(head)) begin
          state_d = IDLE;
        end else begin
          out_d   = head;
          state_d = START;
        end
`else
        out_d   = head;
        state_d = START;
`endif
      end
      START: begin
        if (error) err_d = 1'b1;
        state_d = ARM;
      end
      // A finish still high from the previous move must drop before RUN.
      ARM: begin
        if (error) err_d = 1'b1;
        if (!finish) state_d = RUN;
      end
      RUN: begin
        if (fault_hit)   state_d = FAULT;
        else if (finish) state_d = (level != '0) ? LOAD : IDLE;
      end
      FAULT: begin
        err_d = 1'b0;
        if (fault_clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign speed              = out_q.speed;
  assign num_x_m            = out_q.num_x;
  assign num_y_m            = out_q.num_y;
  assign num_z_m            = out_q.num_z;
  assign num_e0_m           = out_q.num_e0;
  assign num_e1_m           = out_q.num_e1;
  assign start_driving_main = (state_q == START);
  assign fault              = (state_q == FAULT);
  assign busy               = ((state_q != IDLE) && (state_q != FAULT)) || (level != '0);

endmodule

// File: tb/tb_move_queue_dispatcher.sv
// Directed bench for move_queue_dispatcher: dispatch, backpressure, stale
// finish, fault flush, async reset and zero-move handling.
module tb_move_queue_dispatcher;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic        [31:0] cmd_speed = '0;
  logic signed [31:0] cmd_num_x = '0, cmd_num_y = '0, cmd_num_z = '0;
  logic signed [31:0] cmd_num_e0 = '0, cmd_num_e1 = '0;
  logic        [31:0] speed;
  logic signed [31:0] num_x_m, num_y_m, num_z_m, num_e0_m, num_e1_m;
  logic               start_driving_main;
  logic               finish = 1'b0, error = 1'b0, fault_clear = 1'b0;
  logic               busy, fault;
  logic [4:0]         level;

  int n_cmp = 0, n_err = 0, n_starts = 0, s0;
  logic done;

  always #5 clk = ~clk;

  always @(posedge clk) if (start_driving_main) n_starts++;

  move_queue_dispatcher #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_speed(cmd_speed), .cmd_num_x(cmd_num_x), .cmd_num_y(cmd_num_y),
    .cmd_num_z(cmd_num_z), .cmd_num_e0(cmd_num_e0), .cmd_num_e1(cmd_num_e1),
    .speed(speed), .num_x_m(num_x_m), .num_y_m(num_y_m), .num_z_m(num_z_m),
    .num_e0_m(num_e0_m), .num_e1_m(num_e1_m),
    .start_driving_main(start_driving_main), .finish(finish), .error(error),
    .fault_clear(fault_clear), .busy(busy), .fault(fault), .level(level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int sp, input int x, input int y);
    cmd_valid  = v;
    cmd_speed  = sp;
    cmd_num_x  = x;
    cmd_num_y  = y;
    cmd_num_z  = 0;
    cmd_num_e0 = 0;
    cmd_num_e1 = 0;
  endtask

  task automatic push1(input int sp, input int x, input int y);
    drive(1'b1, sp, x, y);
    tick();
    drive(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_start", start_driving_main, 0);
    chk("rst_speed", speed, 0);
    chk("rst_x", num_x_m, 0);
    chk("rst_ready", cmd_ready, 1);

    // Single move: start pulse on the third edge after the push edge counts from it
    push1(1000, 200, -50);
    chk("t1_level", level, 1);
    chk("t1_start_e0", start_driving_main, 0);
    tick();
    chk("t1_start_e1", start_driving_main, 0);
    tick();
    chk("t1_start", start_driving_main, 1);
    chk("t1_speed", speed, 1000);
    chk("t1_x", num_x_m, 200);
    chk("t1_y", num_y_m, -50);
    chk("t1_z", num_z_m, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_pulse_1cyc", start_driving_main, 0);
    tick();
    finish = 1'b1;
    tick();
    chk("t1_busy_done", busy, 0);
    finish = 1'b0;

    // Fill the queue behind one in-flight move
    for (int i = 0; i < 17; i++) push1(i + 1, i, 0);
    chk("t2_level_full", level, 16);
    chk("t2_ready_full", cmd_ready, 0);
    chk("t2_speed_first", speed, 1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("t2_level_preload", level, 16);
    tick();
    chk("t2_level_pop", level, 15);
    chk("t2_ready_pop", cmd_ready, 1);
    chk("t2_speed_second", speed, 2);
    chk("t2_start_second", start_driving_main, 1);
    do_reset();
    chk("t2_level_rst", level, 0);

    // Stale finish held across START must not complete the move
    s0 = n_starts;
    finish = 1'b1;
    push1(500, 1, 1);
    tick();
    tick();
    chk("t3_start", start_driving_main, 1);
    repeat (5) tick();
    chk("t3_busy_armed", busy, 1);
    chk("t3_starts", n_starts - s0, 1);
    finish = 1'b0;
    tick();
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("t3_busy_done", busy, 0);
    chk("t3_starts_end", n_starts - s0, 1);

    // Error and finish together in RUN with 3 queued
    push1(777, 3, 3);
    push1(1, 1, 1);
    push1(2, 2, 2);
    push1(3, 3, 3);
    tick();
    chk("t4_level", level, 3);
    s0 = n_starts;
    error = 1'b1;
    finish = 1'b1;
    tick();
    error = 1'b0;
    finish = 1'b0;
    chk("t4_fault", fault, 1);
    chk("t4_level_flush", level, 0);
    chk("t4_ready", cmd_ready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_speed_kept", speed, 777);
    repeat (4) tick();
    chk("t4_no_start", n_starts - s0, 0);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    chk("t4_fault_clr", fault, 0);
    chk("t4_ready_clr", cmd_ready, 1);
    chk("t4_busy_clr", busy, 0);

    // Reset mid-move with 5 queued
    push1(900, 9, 9);
    for (int i = 0; i < 5; i++) push1(10 + i, 1, 1);
    chk("t5_level", level, 5);
    chk("t5_speed", speed, 900);
    reset = 1'b0;
    #1;
    chk("t5_level_rst", level, 0);
    chk("t5_speed_rst", speed, 0);
    chk("t5_x_rst", num_x_m, 0);
    chk("t5_start_rst", start_driving_main, 0);
    chk("t5_busy_rst", busy, 0);
    tick();
    reset = 1'b1;

    // Zero move sandwiched between two real moves
    s0 = n_starts;
    push1(11, 1, 0);
    push1(22, 0, 0);
    push1(33, 0, 5);
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (start_driving_main) begin
        tick();
        tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
      end else if (!busy) begin
        done = 1'b1;
      end else begin
        tick();
      end
    end
    chk("t6_done", done, 1);
    chk("t6_speed_last", speed, 33);
    chk("t6_y_last", num_y_m, 5);
`ifdef MOVE_QUEUE_SKIP_ZERO_EN
    chk("t6_starts", n_starts - s0, 2);
`else
    chk("t6_starts", n_starts - s0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
